// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and frame constants shared by the UART halves.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;  // 115200 baud from 100 MHz

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserialiser; mid-bit sampling after a synchronised falling edge.
// state    | meaning
// RX_IDLE  | wait for a falling edge while enabled
// RX_START | half-bit wait, then confirm the start bit (else glitch)
// RX_DATA  | sample eight data bits one bit period apart, LSB first
// RX_STOP  | sample stop bit; publish byte only if it is high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_enable,
  input  logic                 i_serial_in,
  output logic [DATA_BITS-1:0] o_rx_buf,
  output logic                 o_rx_valid
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t            r_state,   w_state_nxt;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
  logic [DATA_BITS-1:0] r_rx_buf;
  logic                 r_rx_valid;
  logic                 r_sync1, r_sync2, r_line_prev;
  logic                 w_fall, w_bit_end, w_load;
  logic [CW-1:0]        w_clk_cnt_inc;

  assign w_fall        = r_line_prev & ~r_sync2;
  assign w_bit_end     = (r_clk_cnt == LAST_CLK);
  assign w_clk_cnt_inc = w_bit_end ? '0 : r_clk_cnt + 1'b1;
  assign o_rx_buf      = r_rx_buf;
  assign o_rx_valid    = r_rx_valid;

  // Synchroniser resets to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= i_serial_in;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_buf   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_valid <= w_load;
      if (w_load) r_rx_buf <= r_shift;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_load        = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (i_rx_enable && w_fall) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = RX_START;
        end
      end
      RX_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = r_sync2 ? RX_IDLE : RX_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        w_clk_cnt_nxt = w_clk_cnt_inc;
        if (w_bit_end) begin
          w_shift_nxt   = {r_sync2, r_shift[DATA_BITS-1:1]};
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        w_clk_cnt_nxt = w_clk_cnt_inc;
        if (w_bit_end) begin
          w_load      = r_sync2;
          w_state_nxt = RX_IDLE;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser; sends frames back-to-back while i_tx_enable is high.
// state    | meaning
// TX_IDLE  | line high; latch i_tx_buf and start a frame when enabled
// TX_START | start bit, line low
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit, line high; o_tx_done in its last cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_enable,
  input  logic [DATA_BITS-1:0] i_tx_buf,
  output logic                 o_serial_out,
  output logic                 o_tx_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            r_state,   w_state_nxt;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
  logic                 w_bit_end;
  logic [CW-1:0]        w_clk_cnt_inc;

  assign w_bit_end     = (r_clk_cnt == LAST_CLK);
  assign w_clk_cnt_inc = w_bit_end ? '0 : r_clk_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= TX_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    o_serial_out  = 1'b1;
    o_tx_done     = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_tx_enable) begin
          w_shift_nxt   = i_tx_buf;
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = TX_START;
        end
      end
      TX_START: begin
        o_serial_out  = 1'b0;
        w_clk_cnt_nxt = w_clk_cnt_inc;
        if (w_bit_end) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        o_serial_out  = r_shift[0];
        w_clk_cnt_nxt = w_clk_cnt_inc;
        if (w_bit_end) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        w_clk_cnt_nxt = w_clk_cnt_inc;
        if (w_bit_end) begin
          o_tx_done   = 1'b1;
          w_state_nxt = TX_IDLE;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART; independent TX and RX halves on one clock.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_enable,
  input  logic [DATA_BITS-1:0] i_tx_buf,
  output logic                 o_serial_out,
  output logic                 o_tx_done,
  input  logic                 i_rx_enable,
  input  logic                 i_serial_in,
  output logic [DATA_BITS-1:0] o_rx_buf,
  output logic                 o_rx_valid
);

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tx_enable  (i_tx_enable),
    .i_tx_buf     (i_tx_buf),
    .o_serial_out (o_serial_out),
    .o_tx_done    (o_tx_done)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx_enable (i_rx_enable),
    .i_serial_in (i_serial_in),
    .o_rx_buf    (o_rx_buf),
    .o_rx_valid  (o_rx_valid)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed + randomized checks of uart_core against a frame-level model.
module tb_uart_core;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int LAT   = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset, tx_enable, rx_enable, loop_en, rx_line;
  logic [7:0] tx_buf;
  logic       serial_out, tx_done, rx_valid;
  logic [7:0] rx_buf;
  logic       serial_in;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q_got[$];

  always #5 clk = ~clk;

  assign serial_in = loop_en ? serial_out : rx_line;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tx_enable  (tx_enable),
    .i_tx_buf     (tx_buf),
    .o_serial_out (serial_out),
    .o_tx_done    (tx_done),
    .i_rx_enable  (rx_enable),
    .i_serial_in  (serial_in),
    .o_rx_buf     (rx_buf),
    .o_rx_valid   (rx_valid)
  );

  always @(negedge clk) if (rx_valid) q_got.push_back(rx_buf);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * CPB && !seen; i++) begin
      @(negedge clk);
      if (serial_out === 1'b0) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  // Called on the negedge of start-bit cycle 0; returns on the negedge of the idle gap cycle.
  task automatic check_frame(input logic [7:0] b, input logic [7:0] nxt,
                             input int drop_at, input bit lb);
    logic [9:0] fr;
    int rx_k = -1;
    int rx_n = 0;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      check("tx_line", serial_out, fr[k / CPB]);
      check("tx_done", tx_done, (k == FRAME - 1));
      if (rx_valid === 1'b1) begin
        rx_n++;
        if (rx_k < 0) begin
          rx_k = k;
          check("rx_byte", rx_buf, b);
        end
      end
      if (k == drop_at) tx_enable = 1'b0;
      if (k == FRAME - 1) tx_buf = nxt;
    end
    if (lb) begin
      check("rx_pulses", rx_n, 1);
      check("rx_latency", (rx_k >= LAT - 1 && rx_k <= LAT + 1), 1'b1);
    end
    @(negedge clk);
    check("gap_line", serial_out, 1'b1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx_line = fr[j];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] g, r;
    int base, bad, glen;

    reset = 1'b1; tx_enable = 1'b0; rx_enable = 1'b0;
    tx_buf = 8'h00; loop_en = 1'b1; rx_line = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_buf", rx_buf, 8'h00);
    reset = 1'b0;

    // Loopback: FE, back-to-back 13, then 13 again with enable dropped mid-frame.
    tx_buf = 8'hFE; rx_enable = 1'b1; tx_enable = 1'b1;
    wait_start("start_fe");
    check_frame(8'hFE, 8'h13, -1, 1'b1);
    @(negedge clk);
    check_frame(8'h13, 8'h13, -1, 1'b1);
    @(negedge clk);
    check_frame(8'h13, 8'h13, 5 * CPB, 1'b1);

    base = q_got.size();
    bad = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    check("pause_line_idle", bad, 0);
    check("pause_no_rx", q_got.size() - base, 0);

    // Resume stream: fixed bytes then random ones, each changed on tx_done.
    bytes = '{8'h37, 8'h38, 8'h39, 8'h40};
    for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom));
    base = q_got.size();
    tx_buf = bytes[0]; tx_enable = 1'b1;
    wait_start("start_resume");
    for (int i = 0; i < bytes.size(); i++) begin
      if (i > 0) @(negedge clk);
      check_frame(bytes[i], (i < bytes.size() - 1) ? bytes[i + 1] : bytes[i],
                  (i == bytes.size() - 1) ? CPB : -1, 1'b1);
    end
    repeat (2 * CPB) @(negedge clk);
    check("resume_count", q_got.size() - base, bytes.size());
    for (int i = 0; i < bytes.size() && base + i < q_got.size(); i++)
      check("resume_order", q_got[base + i], bytes[i]);

    // Reset in the middle of a frame.
    tx_buf = 8'($urandom); tx_enable = 1'b1;
    wait_start("start_abort");
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1; tx_enable = 1'b0;
    @(negedge clk);
    check("midrst_serial_out", serial_out, 1'b1);
    check("midrst_tx_done", tx_done, 1'b0);
    check("midrst_rx_buf", rx_buf, 8'h00);
    reset = 1'b0;
    base = q_got.size();
    repeat (12 * CPB) @(negedge clk);
    check("midrst_no_rx", q_got.size() - base, 0);

    // Bench-driven RX line.
    loop_en = 1'b0;
    g = 8'($urandom);
    base = q_got.size();
    drive_frame(g, 1'b1);
    check("rx_good_count", q_got.size() - base, 1);
    check("rx_good_buf", rx_buf, g);

    for (int i = 0; i < 3; i++) begin
      glen = (i == 0) ? CPB / 4 : int'($urandom_range(CPB / 2 - 2, 1));
      rx_line = 1'b0;
      repeat (glen) @(negedge clk);
      rx_line = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
    check("glitch_no_rx", q_got.size() - base, 1);
    check("glitch_buf_held", rx_buf, g);

    drive_frame(~g, 1'b0);
    check("framing_no_rx", q_got.size() - base, 1);
    check("framing_buf_held", rx_buf, g);

    rx_enable = 1'b0;
    drive_frame(8'($urandom), 1'b1);
    check("rx_disabled_ignored", q_got.size() - base, 1);

    rx_enable = 1'b1;
    r = 8'($urandom);
    drive_frame(r, 1'b1);
    check("rx_recover_count", q_got.size() - base, 2);
    check("rx_recover_buf", rx_buf, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
